cntr_param: RTL

CNTR_PARAM -- requirements
Module: cntr_param

---
 rtl/cntr_param.sv | 110 +++++++++++
 1 files changed

// File: rtl/cntr_param.sv
// Parameterised up/down counter with parallel load, optional saturation,
// terminal-count pulse and sticky boundary flag, all outputs registered.
module cntr_param #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             inc,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic [2:0]       o_state,
   output logic             tc,
   output logic             ovf
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'b000,
      ST_LOAD = 3'b001,
      ST_HOLD = 3'b010,
      ST_UP   = 3'b011,
      ST_DOWN = 3'b100
   } state_t;

   localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] MIN_VAL  = '0;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   dn_diff;
   logic             up_bnd;
   logic             dn_bnd;
   logic [WIDTH-1:0] up_val;
   logic [WIDTH-1:0] dn_val;

   // In saturating mode, landing on the clamp value also counts as a boundary
   // event, so tc fires on reaching the limit as well as on every clamped cycle.
   always_comb begin
      up_sum  = {1'b0, count_q} + STEP_EXT;
      dn_diff = {1'b0, count_q} - STEP_EXT;
      up_bnd  = up_sum[WIDTH];
      dn_bnd  = dn_diff[WIDTH];
      up_val  = up_sum[WIDTH-1:0];
      dn_val  = dn_diff[WIDTH-1:0];
      if (SAT) begin
         up_bnd = up_sum[WIDTH] || (up_sum[WIDTH-1:0] == MAX_VAL);
         dn_bnd = dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] == MIN_VAL);
         if (up_sum[WIDTH]) begin
            up_val = MAX_VAL;
         end
         if (dn_diff[WIDTH]) begin
            dn_val = MIN_VAL;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q;
      if (load) begin
         count_d = d_in;
         state_d = ST_LOAD;
         ovf_d   = 1'b0;
      end else if (en) begin
         if (inc) begin
            count_d = up_val;
            state_d = ST_UP;
            tc_d    = up_bnd;
            ovf_d   = ovf_q | up_bnd;
         end else begin
            count_d = dn_val;
            state_d = ST_DOWN;
            tc_d    = dn_bnd;
            ovf_d   = ovf_q | dn_bnd;
         end
      end else begin
         state_d = (state_q == ST_IDLE) ? ST_IDLE : ST_HOLD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign d_out   = count_q;
   assign o_state = state_q;
   assign tc      = tc_q;
   assign ovf     = ovf_q;

endmodule
